// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for a single-write-port register file: two one-entry slots
// (ALU and load), program-order issue, and read-address pending flags for decode stalls.
module regfile_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteAddress,
  output logic [DATA_W-1:0] DataIn,
  input  logic [ADDR_W-1:0] Address1,
  input  logic [ADDR_W-1:0] Address2,
  output logic              Pending1,
  output logic              Pending2
);

  typedef enum logic [2:0] {EMPTY, A_ONLY, M_ONLY, A_OLD, M_OLD} state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] slot_a_addr;
  logic [DATA_W-1:0] slot_a_data;
  logic [ADDR_W-1:0] slot_m_addr;
  logic [DATA_W-1:0] slot_m_data;

  logic a_full, m_full, grant_a, grant_m;
  logic a_take, m_take, a_keep, m_keep;

  assign a_full  = (state == A_ONLY) || (state == A_OLD) || (state == M_OLD);
  assign m_full  = (state == M_ONLY) || (state == A_OLD) || (state == M_OLD);
  assign grant_a = (state == A_ONLY) || (state == A_OLD);
  assign grant_m = (state == M_ONLY) || (state == M_OLD);

  assign a_ready = !a_full || grant_a;
  assign m_ready = !m_full || grant_m;
  assign a_take  = a_valid && a_ready;
  assign m_take  = m_valid && m_ready;
  // Entries that survive this edge: full and not being drained by the grant.
  assign a_keep  = a_full && !grant_a;
  assign m_keep  = m_full && !grant_m;

  always_comb begin
    state_next = EMPTY;
    if ((a_keep || a_take) && (m_keep || m_take)) begin
      // The surviving entry is older than any fresh one; two fresh entries put the load first.
      state_next = a_keep ? A_OLD : M_OLD;
    end else if (a_keep || a_take) begin
      state_next = A_ONLY;
    end else if (m_keep || m_take) begin
      state_next = M_ONLY;
    end
  end

  assign WriteAddress = grant_a ? slot_a_addr : (grant_m ? slot_m_addr : '0);
  assign DataIn       = grant_a ? slot_a_data : (grant_m ? slot_m_data : '0);
  // Register 0 is hardwired, so a granted write to it drains without a pulse.
  assign RegWrite     = (grant_a || grant_m) && (WriteAddress != '0);

  assign Pending1 = (Address1 != '0) &&
                    ((a_full && (slot_a_addr == Address1)) || (m_full && (slot_m_addr == Address1)));
  assign Pending2 = (Address2 != '0) &&
                    ((a_full && (slot_a_addr == Address2)) || (m_full && (slot_m_addr == Address2)));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state       <= EMPTY;
      slot_a_addr <= '0;
      slot_a_data <= '0;
      slot_m_addr <= '0;
      slot_m_data <= '0;
    end else begin
      state <= state_next;
      if (a_take) begin
        slot_a_addr <= a_addr;
        slot_a_data <= a_data;
      end
      if (m_take) begin
        slot_m_addr <= m_addr;
        slot_m_data <= m_data;
      end
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and scoreboard for the single-write-port MIPS register file. It accepts writeback requests from the ALU stage (A) and the load/memory stage (M) through valid/ready handshakes and holds each request in a one-entry slot. It issues at most one register write per cycle, in program order, and reports whether either read address has a write still pending so the decode stage can stall.

## Interface
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_valid  in  1  ALU writeback request.
- a_addr  in  ADDR_W  ALU destination register.
- a_data  in  DATA_W  ALU result.
- a_ready  out  1  A slot can accept this cycle.
- m_valid  in  1  load writeback request.
- m_addr  in  ADDR_W  load destination register.
- m_data  in  DATA_W  load data.
- m_ready  out  1  M slot can accept this cycle.
- RegWrite  out  1  register-file write enable.
- WriteAddress  out  ADDR_W  register-file write address.
- DataIn  out  DATA_W  register-file write data.
- Address1, Address2  in  ADDR_W  decode-stage read addresses.
- Pending1, Pending2  out  1  read address has a held, unissued write.

## Operation
- Each requester has one slot holding full, addr and data. A request is accepted on a rising edge when valid and ready are both high.
- Ordering FSM:
  - EMPTY: no slot is full.
  - A_ONLY: only the A slot is full.
  - M_ONLY: only the M slot is full.
  - A_OLD: both slots are full and the A slot is older.
  - M_OLD: both slots are full and the M slot is older.
- Grant selection:
  - In A_ONLY, grant A. In M_ONLY, grant M.
  - In A_OLD, grant A. In M_OLD, grant M.
  - In EMPTY, nothing is granted.
- The granted slot drives WriteAddress and DataIn. RegWrite equals (granted slot full) AND (addr != 0).
- A granted write to address 0 is drained silently: the slot empties and RegWrite stays low.
- The granted slot empties at the next edge.
- Transitions are computed from the state after the drain, then the new acceptances:
  - A fills while M remains full: next state M_OLD.
  - M fills while A remains full: next state A_OLD.
  - Both fill in the same cycle from empty slots: next state M_OLD. The load is the older instruction.
  - The granted slot drains and is refilled in the same cycle: the refilled entry is younger than the other full slot.
  - Only one slot is left full: next state A_ONLY or M_ONLY.
  - Neither slot is full: next state EMPTY.
- Ready rules:
  - a_ready = !a_full OR (grant is A).
  - m_ready = !m_full OR (grant is M).
  - The ungranted full slot is not ready.
- Pending rule: PendingN = OR over full slots of (slot addr == AddressN), forced to 0 when AddressN == 0. An entry that is granted this cycle still counts as pending.
- Widths: addresses compare over the full ADDR_W bits. Data passes through unmodified.
- No forwarding is performed. The decode stage stalls on PendingN.

## Timing
- Reset (asynchronous assert, synchronous-edge release): state EMPTY, both slots empty.
- Outputs while reset is asserted or the block is idle:
  - RegWrite=0, WriteAddress=0, DataIn=0.
  - a_ready=1, m_ready=1.
  - Pending1=0, Pending2=0.
- Reset mid-operation discards held writes. No RegWrite pulse occurs after reset deasserts.
- Latency: request accepted at edge N; RegWrite high during cycle N+1 (combinational from the slot); register updated at edge N+1. Minimum 1 cycle, acceptance to commit.
- Throughput: one register write per cycle total. A requester granted every cycle sustains one accept per cycle.
- Worst-case wait: a slot whose partner is older waits exactly 1 extra cycle.
- The slot is loaded only on handshake. While valid is high and ready is low, the requester must hold its address and data stable.
- Same destination held in both slots: the older slot writes first and the younger writes second, so the younger value is final.

## Test plan
- Single A write: accept (a_addr=5, a_data=0xDEADBEEF) at edge 0 → cycle 1 shows RegWrite=1, WriteAddress=5, DataIn=0xDEADBEEF, Pending for Address1=5 is 1; cycle 2 shows RegWrite=0 and Pending=0.
- Simultaneous accept from EMPTY (A: r3=1, M: r3=2) → M writes r3=2 in cycle 1, then A writes r3=1 in cycle 2; a_ready=0 in cycle 1; final r3=1.
- Ordering: A accepted at edge 0 (r7=0xA), M accepted at edge 1 while A is stalled by a held grant → writes issue in acceptance order and the FSM reaches A_OLD; also check that refilling a drained slot marks it younger.
- Address-0 drain: accept M addr=0 → RegWrite never asserts, m_ready returns to 1, Pending1 with Address1=0 stays 0.
- Back-to-back streaming: a_valid high for 10 cycles with no M traffic → 10 writes in 10 consecutive cycles and a_ready constantly 1.
- Async reset: assert reset (low) mid-cycle with both slots full → outputs clear immediately; after release, no RegWrite until a new handshake occurs.
